// File: rtl/acia_rx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : acia_rx_feeder
// Description : Byte FIFO plus 8N1 serializer that drives the ACIA rx line.
//               The bit rate is latched per frame. Optional idle-high gap
//               bits can follow each stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module acia_rx_feeder #(
    parameter int ADDR_W        = 4,
    parameter int BIT_CLKS_SLOW = 4096,
    parameter int BIT_CLKS_FAST = 1024,
    parameter int GAP_BITS      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic              wr,
    input  logic              rate_sel,
    output logic              tx,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow
);

    localparam int c_DEPTH    = 1 << ADDR_W;
    localparam int c_MAX_CLKS = (BIT_CLKS_SLOW > BIT_CLKS_FAST) ? BIT_CLKS_SLOW : BIT_CLKS_FAST;
    localparam int c_GAP_MULT = (GAP_BITS > 0) ? GAP_BITS : 1;
    localparam int c_CNT_W    = $clog2(c_MAX_CLKS * c_GAP_MULT + 1);

    localparam logic [ADDR_W:0]    c_FULL_CNT      = (ADDR_W+1)'(c_DEPTH);
    localparam logic [c_CNT_W-1:0] c_SLOW_LAST     = c_CNT_W'(BIT_CLKS_SLOW - 1);
    localparam logic [c_CNT_W-1:0] c_FAST_LAST     = c_CNT_W'(BIT_CLKS_FAST - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_SLOW_LAST = c_CNT_W'(c_GAP_MULT * BIT_CLKS_SLOW - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_FAST_LAST = c_CNT_W'(c_GAP_MULT * BIT_CLKS_FAST - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;

    // Input capture stage and FIFO storage
    logic              r_in_vld;
    logic [7:0]        r_in_data;
    logic [7:0]        r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_push;
    logic              w_pop;
    logic [7:0]        w_head;

    // Serializer state
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_fast;
    logic               r_tx;
    logic               r_busy;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_fast_nxt;
    logic               w_tx_nxt;
    logic               w_busy_nxt;
    logic               w_try_load;
    logic               w_bit_done;
    logic               w_gap_done;

    // A captured write lands in the FIFO one edge after it is strobed, so a
    // write only commits if the FIFO is not full at that commit edge.
    assign w_push = r_in_vld && !r_full;
    assign w_head = r_mem[r_rd_ptr];

    // Next occupancy from simultaneous push/pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_vld   <= 1'b0;
            r_in_data  <= 8'h00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_in_vld  <= wr;
            r_in_data <= din;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_in_vld && r_full) r_overflow <= 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // FIFO storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_in_data;
    end

    assign w_bit_done = (r_cnt == (r_fast ? c_FAST_LAST : c_SLOW_LAST));
    assign w_gap_done = (r_cnt == (r_fast ? c_GAP_FAST_LAST : c_GAP_SLOW_LAST));

    // Serializer next-state, bit timing and line level
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_fast_nxt  = r_fast;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_pop       = 1'b0;
        w_try_load  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_try_load = 1'b1;
            end
            c_ST_START: begin
                if (w_bit_done) begin
                    w_state_nxt = c_ST_DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            c_ST_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            c_ST_STOP: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (GAP_BITS > 0) w_state_nxt = c_ST_GAP;
                    else              w_try_load  = 1'b1;
                end
            end
            c_ST_GAP: begin
                if (w_gap_done) w_try_load = 1'b1;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
        // Idle or final clock of a frame: start the next frame back-to-back
        // when a byte is waiting, otherwise return the line to idle.
        if (w_try_load) begin
            w_cnt_nxt = '0;
            if (!r_empty) begin
                w_pop       = 1'b1;
                w_shift_nxt = w_head;
                w_fast_nxt  = rate_sel;
                w_tx_nxt    = 1'b0;
                w_busy_nxt  = 1'b1;
                w_state_nxt = c_ST_START;
            end else begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_fast  <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_fast  <= w_fast_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_acia_rx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_acia_rx_feeder
// Description : Self-checking bench for acia_rx_feeder. Two instances share
//               the stimulus: one without gap bits, one with GAP_BITS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acia_rx_feeder;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       wr;
    logic       rate_sel;

    logic       tx0, full0, empty0, busy0, ovf0;
    logic [2:0] count0;
    logic       tx1, full1, empty1, busy1, ovf1;
    logic [2:0] count1;

    acia_rx_feeder #(.ADDR_W(2), .BIT_CLKS_SLOW(16), .BIT_CLKS_FAST(4), .GAP_BITS(0)) dut (
        .clk(clk), .reset(reset), .din(din), .wr(wr), .rate_sel(rate_sel),
        .tx(tx0), .full(full0), .empty(empty0), .count(count0), .busy(busy0), .overflow(ovf0)
    );

    acia_rx_feeder #(.ADDR_W(2), .BIT_CLKS_SLOW(16), .BIT_CLKS_FAST(4), .GAP_BITS(2)) dut_gap (
        .clk(clk), .reset(reset), .din(din), .wr(wr), .rate_sel(rate_sel),
        .tx(tx1), .full(full1), .empty(empty1), .count(count1), .busy(busy1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of bytes per instance, plus the current frame described as
    // "clocks elapsed since the frame started" and its bit period.
    logic [7:0] m_q [2][4];
    int         m_head [2];
    int         m_size [2];
    bit         m_act  [2];
    int         m_t    [2];
    int         m_p    [2];
    logic [7:0] m_data [2];
    bit         m_ovf  [2];
    bit         m_pend;
    logic [7:0] m_pdin;
    bit         m_valid = 1'b0;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic exp_tx(input int k);
        int b;
        if (!m_act[k]) return 1'b1;
        b = m_t[k] / m_p[k];
        if (b == 0) return 1'b0;
        if (b <= 8) return m_data[k][b-1];
        return 1'b1;
    endfunction

    bit         mdl_acc;
    bit         mdl_pop;
    logic [7:0] mdl_b;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_head[k] = 0; m_size[k] = 0; m_act[k] = 0; m_t[k] = 0;
                m_p[k] = 16; m_data[k] = 8'h00; m_ovf[k] = 0;
            end else begin
                // a write lands one edge after its strobe
                mdl_acc = m_pend && (m_size[k] < 4);
                if (m_pend && !mdl_acc) m_ovf[k] = 1'b1;
                mdl_pop = (m_size[k] > 0) &&
                          (!m_act[k] || m_t[k] == (10 + gap_of(k)) * m_p[k] - 1);
                mdl_b = 8'h00;
                if (mdl_pop) begin
                    mdl_b = m_q[k][m_head[k]];
                    m_head[k] = (m_head[k] + 1) % 4;
                    m_size[k] = m_size[k] - 1;
                end
                if (mdl_acc) begin
                    m_q[k][(m_head[k] + m_size[k]) % 4] = m_pdin;
                    m_size[k] = m_size[k] + 1;
                end
                if (mdl_pop) begin
                    m_act[k] = 1'b1; m_t[k] = 0; m_data[k] = mdl_b;
                    m_p[k] = rate_sel ? 4 : 16;
                end else if (m_act[k]) begin
                    if (m_t[k] == (10 + gap_of(k)) * m_p[k] - 1) m_act[k] = 1'b0;
                    else m_t[k] = m_t[k] + 1;
                end
            end
        end
        m_pend = reset ? 1'b0 : wr;
        m_pdin = din;
        if (reset) m_valid = 1'b1;
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx0",    tx0,    exp_tx(0));
            chk("busy0",  busy0,  m_act[0]);
            chk("count0", count0, m_size[0]);
            chk("empty0", empty0, m_size[0] == 0);
            chk("full0",  full0,  m_size[0] == 4);
            chk("ovf0",   ovf0,   m_ovf[0]);
            chk("tx1",    tx1,    exp_tx(1));
            chk("busy1",  busy1,  m_act[1]);
            chk("count1", count1, m_size[1]);
            chk("empty1", empty1, m_size[1] == 0);
            chk("full1",  full1,  m_size[1] == 4);
            chk("ovf1",   ovf1,   m_ovf[1]);
        end
    end

    // Line recorder: tx of each busy cycle, indexed by busy-cycle number
    logic line0 [4096];
    logic line1 [4096];
    int   mc0 = 0;
    int   mc1 = 0;
    always @(negedge clk) begin
        if (busy0 === 1'b1) begin line0[mc0 % 4096] = tx0; mc0++; end
        if (busy1 === 1'b1) begin line1[mc1 % 4096] = tx1; mc1++; end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] vb [8];
    int         base0, base1;
    logic [9:0] exp_line;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_bytes(input int n, input logic rs);
        for (int i = 0; i < n; i++) begin
            din = vb[i]; wr = 1'b1; rate_sel = rs;
            step();
        end
        wr = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        step(); step(); step();
        while ((busy0 || busy1 || !empty0 || !empty1) && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", n < max, 1);
    endtask

    task automatic mark();
        base0 = mc0;
        base1 = mc1;
    endtask

    initial begin
        reset = 1'b1; din = 8'h00; wr = 1'b0; rate_sel = 1'b0;
        step();
        chk("rst_tx", tx0, 1); chk("rst_busy", busy0, 0); chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0); chk("rst_count", count0, 0); chk("rst_ovf", ovf0, 0);
        reset = 1'b0;
        step();

        // 1: single byte 0xA5, fast rate
        mark();
        vb[0] = 8'hA5;
        wr_bytes(1, 1'b1);
        step();
        chk("t1_empty_e1", empty0, 0);
        chk("t1_busy_e1", busy0, 0);
        step();
        chk("t1_busy_e2", busy0, 1);
        chk("t1_tx_e2", tx0, 0);
        wait_idle(500);
        exp_line = 10'b1101001010;
        for (int b = 0; b < 10; b++) chk($sformatf("t1_bit%0d", b), line0[(base0 + 4*b + 2) % 4096], exp_line[b]);
        chk("t1_len0", mc0 - base0, 40);
        chk("t1_len1", mc1 - base1, 48);
        chk("t1_empty", empty0, 1);

        // 2: 0x00 then 0xFF back-to-back
        mark();
        vb[0] = 8'h00; vb[1] = 8'hFF;
        wr_bytes(2, 1'b1);
        wait_idle(500);
        chk("t2_len0", mc0 - base0, 80);
        chk("t2_stop", line0[(base0 + 39) % 4096], 1);
        chk("t2_start2", line0[(base0 + 40) % 4096], 0);
        chk("t2_d0", line0[(base0 + 44) % 4096], 1);
        chk("t2_len1", mc1 - base1, 96);

        // 3: overflow while a frame is active
        mark();
        vb[0] = 8'h11;
        wr_bytes(1, 1'b1);
        step(); step();
        chk("t3_active", busy0, 1);
        for (int i = 0; i < 5; i++) vb[i] = 8'h21 + 8'(i);
        wr_bytes(5, 1'b1);
        step();
        chk("t3_count", count0, 4);
        chk("t3_full", full0, 1);
        chk("t3_ovf", ovf0, 1);
        chk("t3_ovf_g", ovf1, 1);
        wait_idle(1000);
        chk("t3_len0", mc0 - base0, 200);
        chk("t3_len1", mc1 - base1, 240);
        chk("t3_ovf_held", ovf0, 1);
        reset = 1'b1;
        step();
        chk("t3_ovf_clr", ovf0, 0);
        reset = 1'b0;
        step();

        // 4: slow frame with rate toggled mid-frame, then a fast frame
        mark();
        vb[0] = 8'h3C;
        wr_bytes(1, 1'b0);
        for (int i = 0; i < 10; i++) step();
        vb[0] = 8'h5A;
        wr_bytes(1, 1'b1);
        wait_idle(1000);
        chk("t4_len0", mc0 - base0, 200);
        chk("t4_len1", mc1 - base1, 240);
        chk("t4_start", line0[(base0 + 8) % 4096], 0);
        chk("t4_b0", line0[(base0 + 24) % 4096], 0);
        chk("t4_b2", line0[(base0 + 56) % 4096], 1);
        chk("t4_stop", line0[(base0 + 152) % 4096], 1);
        chk("t4_n_start", line0[(base0 + 162) % 4096], 0);
        chk("t4_n_b0", line0[(base0 + 166) % 4096], 0);
        chk("t4_n_b1", line0[(base0 + 170) % 4096], 1);

        // 5: gap bits between two queued frames
        mark();
        vb[0] = 8'h81; vb[1] = 8'h7E;
        wr_bytes(2, 1'b1);
        wait_idle(1000);
        chk("t5_len1", mc1 - base1, 96);
        chk("t5_b0", line1[(base1 + 6) % 4096], 1);
        chk("t5_stop", line1[(base1 + 38) % 4096], 1);
        chk("t5_gap_a", line1[(base1 + 42) % 4096], 1);
        chk("t5_gap_b", line1[(base1 + 47) % 4096], 1);
        chk("t5_start2", line1[(base1 + 48) % 4096], 0);
        chk("t5_len0", mc0 - base0, 80);
        chk("t5_start2_0", line0[(base0 + 40) % 4096], 0);

        // 6: reset during DATA with two bytes queued
        vb[0] = 8'h01; vb[1] = 8'h02; vb[2] = 8'h03;
        wr_bytes(3, 1'b1);
        for (int i = 0; i < 8; i++) step();
        chk("t6_busy", busy0, 1);
        chk("t6_count", count0, 2);
        reset = 1'b1;
        step();
        chk("t6_tx", tx0, 1); chk("t6_busy0", busy0, 0);
        chk("t6_count0", count0, 0); chk("t6_empty0", empty0, 1);
        chk("t6_tx1", tx1, 1); chk("t6_busy1", busy1, 0);
        reset = 1'b0;
        mark();
        for (int i = 0; i < 100; i++) step();
        chk("t6_quiet0", mc0 - base0, 0);
        chk("t6_quiet1", mc1 - base1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
